// File: rtl/component_register_ctrl_if.sv
// Request/response bundle shared by the two requesters of the component register block.
// Request side is valid/ready per requester; response side is valid/ready per requester.
// Read data and error are shared and qualified by the per-requester response valid.
interface component_register_ctrl_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][3:0]  req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_wstrb;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [31:0]      resp_rdata;
  logic             resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/component_register_ctrl.sv
// Round-robin access controller for the packed 64-bit component register block.
// Latency: request accepted at T, register and response visible at T+2.
// Backpressure: one transaction in flight; all requests stall until the response handshakes.
module component_register_ctrl #(
  parameter int                       REGISTER_BITS = 64,  // two 32-bit words
  parameter logic [REGISTER_BITS-1:0] READ_MASK     = '1,
  parameter logic [REGISTER_BITS-1:0] WRITE_MASK    = 64'hFFFF_FFFF_0000_0000,
  parameter logic [REGISTER_BITS-1:0] RESET_VALUE   = 64'h0040_1020_ABCD_1234
) (
  input  logic                     clk,
  input  logic                     rst,
  component_register_ctrl_if.slave bus,
  output logic [REGISTER_BITS-1:0] regs_out,
  output logic                     regs_update
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Captured request and arbitration history
  logic        r_last_grant;
  logic        r_gnt;
  logic        r_write;
  logic [3:0]  r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  // Register contents and registered response
  logic [REGISTER_BITS-1:0] r_regs;
  logic [31:0]              r_rdata;
  logic                     r_error;
  logic                     r_update;

  logic       w_grant_idx;
  logic       w_capture;
  logic [1:0] w_req_ready;
  logic [1:0] w_resp_valid;

  logic                     w_addr_ok;
  logic [5:0]               w_word_base;
  logic [31:0]              w_old_word;
  logic [31:0]              w_wmask_word;
  logic [31:0]              w_rmask_word;
  logic [31:0]              w_strb_bits;
  logic [31:0]              w_bit_en;
  logic [31:0]              w_new_word;
  logic [REGISTER_BITS-1:0] w_regs_nxt;

  // Round-robin pick: on contention the requester not served last wins
  always_comb begin
    w_grant_idx = 1'b0;
    if (bus.req_valid == 2'b11) begin
      w_grant_idx = ~r_last_grant;
    end else begin
      w_grant_idx = bus.req_valid[1];
    end
  end

  // Next-state and handshake decode; ready is withheld while reset is asserted
  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = 2'b00;
    w_resp_valid = 2'b00;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((|bus.req_valid) && !rst) begin
          w_req_ready[w_grant_idx] = 1'b1;
          w_capture                = 1'b1;
          w_state_nxt              = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_resp_valid[r_gnt] = 1'b1;
        if (bus.resp_ready[r_gnt]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Word select and bit-level merge of write data under strobe and write mask
  always_comb begin
    w_addr_ok    = (r_addr[3:1] == 3'd0);
    w_word_base  = {r_addr[0], 5'd0};
    w_old_word   = r_regs[w_word_base +: 32];
    w_wmask_word = WRITE_MASK[w_word_base +: 32];
    w_rmask_word = READ_MASK[w_word_base +: 32];
    w_strb_bits  = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
    w_bit_en     = w_strb_bits & w_wmask_word;
    w_new_word   = (w_old_word & ~w_bit_en) | (r_wdata & w_bit_en);
    w_regs_nxt   = r_regs;
    w_regs_nxt[w_word_base +: 32] = w_new_word;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the granted request; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= 4'd0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
    end else if (w_capture) begin
      r_last_grant <= w_grant_idx;
      r_gnt        <= w_grant_idx;
      r_write      <= bus.req_write[w_grant_idx];
      r_addr       <= bus.req_addr[w_grant_idx];
      r_wdata      <= bus.req_wdata[w_grant_idx];
      r_wstrb      <= bus.req_wstrb[w_grant_idx];
    end
  end

  // Perform the access in ACCESS; response fields then hold through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs   <= RESET_VALUE;
      r_rdata  <= 32'd0;
      r_error  <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (r_state == ST_ACCESS) begin
        if (!w_addr_ok) begin
          r_rdata <= 32'd0;
          r_error <= 1'b1;
        end else if (r_write) begin
          r_rdata  <= 32'd0;
          r_error  <= 1'b0;
          r_regs   <= w_regs_nxt;
          r_update <= (w_regs_nxt != r_regs);
        end else begin
          r_rdata <= w_old_word & w_rmask_word;
          r_error <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_error = r_error;
  assign regs_out       = r_regs;
  assign regs_update    = r_update;

endmodule

// File: tb/tb_component_register_ctrl.sv
// Bench for component_register_ctrl: directed scenarios followed by random traffic,
// all checked each cycle against a transaction-level model of the register block.
module tb_component_register_ctrl;

  localparam logic [63:0] RESET_VALUE = 64'h0040_1020_ABCD_1234;
  localparam logic [63:0] WMASK       = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] RMASK       = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [63:0] regs_out;
  logic        regs_update;

  component_register_ctrl_if bif();

  component_register_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif),
    .regs_out    (regs_out),
    .regs_update (regs_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        wr;
    bit [3:0]  addr;
    bit [31:0] wdata;
    bit [3:0]  wstrb;
    int        hold;
  } op_t;

  op_t ops [2][0:511];
  int  head [2];
  int  tail [2];
  bit  pres [2];
  bit  wait_rsp [2];
  int  hold_cnt [2];
  bit  acc_now [2];
  bit  done_now [2];
  bit  allow_drop;

  // transaction-level model state
  logic [63:0] m_regs;
  logic [63:0] m_new;
  logic [31:0] m_rdata;
  logic        m_err;
  bit          m_busy;
  int          m_owner;
  int          m_last;
  int          m_apply;

  int          cyc;
  int          upd_cnt;
  int          upd_base;
  int          base;
  int          n_log;
  int          log_owner [0:1023];
  logic [31:0] log_rdata [0:1023];
  logic        log_err   [0:1023];

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input bit wr, input bit [3:0] a, input bit [31:0] d,
                      input bit [3:0] s, input int hold);
    ops[r][tail[r]] = '{wr, a, d, s, hold};
    tail[r]++;
  endtask

  task automatic model_reset();
    m_regs = RESET_VALUE;
    m_new  = RESET_VALUE;
    m_busy = 1'b0;
    m_last = 1;
    for (int r = 0; r < 2; r++) begin
      acc_now[r]  = 1'b0;
      done_now[r] = 1'b0;
    end
  endtask

  // Word-level semantics of one access computed straight from the register map
  task automatic model_accept(input int g);
    logic [3:0]  a;
    logic [31:0] word;
    logic [63:0] wm;
    logic [63:0] rm;
    a       = bif.req_addr[g];
    wm      = WMASK;
    rm      = RMASK;
    m_new   = m_regs;
    m_rdata = 32'd0;
    m_err   = 1'b0;
    if (a > 4'd1) begin
      m_err = 1'b1;
    end else begin
      word = 32'(m_regs >> (32 * a));
      for (int b = 0; b < 32; b++) begin
        if (bif.req_write[g]) begin
          if (bif.req_wstrb[g][b / 8] && wm[32 * a + b]) m_new[32 * a + b] = bif.req_wdata[g][b];
        end else begin
          m_rdata[b] = word[b] & rm[32 * a + b];
        end
      end
    end
    m_busy  = 1'b1;
    m_owner = g;
    m_apply = cyc + 2;
    m_last  = g;
  endtask

  task automatic present(input int r);
    bif.req_valid[r] = 1'b1;
    bif.req_write[r] = ops[r][head[r]].wr;
    bif.req_addr[r]  = ops[r][head[r]].addr;
    bif.req_wdata[r] = ops[r][head[r]].wdata;
    bif.req_wstrb[r] = ops[r][head[r]].wstrb;
    pres[r] = 1'b1;
  endtask

  task automatic drive_phase();
    for (int r = 0; r < 2; r++) begin
      if (acc_now[r]) begin
        bif.req_valid[r] = 1'b0;
        pres[r]     = 1'b0;
        wait_rsp[r] = 1'b1;
        hold_cnt[r] = 0;
        acc_now[r]  = 1'b0;
      end
      if (done_now[r]) begin
        bif.resp_ready[r] = 1'b0;
        wait_rsp[r] = 1'b0;
        head[r]++;
        done_now[r] = 1'b0;
      end
      if (wait_rsp[r] && !bif.resp_ready[r] && hold_cnt[r] >= ops[r][head[r]].hold)
        bif.resp_ready[r] = 1'b1;
      if (pres[r] && allow_drop && $urandom_range(0, 9) == 0) begin
        bif.req_valid[r] = 1'b0;
        pres[r] = 1'b0;
        head[r]++;
      end else if (!pres[r] && !wait_rsp[r] && head[r] < tail[r]) begin
        present(r);
      end
    end
  endtask

  task automatic sample_phase();
    logic [1:0] exp_rv;
    logic [1:0] exp_rdy;
    logic [1:0] v;
    logic       upd;
    int         g;
    upd = 1'b0;
    if (m_busy && cyc == m_apply) begin
      upd    = (m_new != m_regs);
      m_regs = m_new;
    end
    check("regs_out", regs_out, m_regs);
    check("regs_update", 64'(regs_update), 64'(upd));
    if (regs_update === 1'b1) upd_cnt++;
    exp_rv = (m_busy && cyc >= m_apply) ? 2'(1 << m_owner) : 2'b00;
    check("resp_valid", 64'(bif.resp_valid), 64'(exp_rv));
    if (exp_rv != 2'b00) begin
      check("resp_rdata", 64'(bif.resp_rdata), 64'(m_rdata));
      check("resp_error", 64'(bif.resp_error), 64'(m_err));
    end
    v       = bif.req_valid;
    exp_rdy = 2'b00;
    g       = 0;
    if (!m_busy && v != 2'b00) begin
      g       = (v == 2'b11) ? (m_last == 0 ? 1 : 0) : (v[1] ? 1 : 0);
      exp_rdy = 2'(1 << g);
    end
    check("req_ready", 64'(bif.req_ready), 64'(exp_rdy));
    for (int r = 0; r < 2; r++) begin
      acc_now[r]  = v[r] && bif.req_ready[r];
      done_now[r] = bif.resp_valid[r] && bif.resp_ready[r];
      if (wait_rsp[r] && bif.resp_valid[r] && !bif.resp_ready[r]) hold_cnt[r]++;
    end
    if (exp_rv != 2'b00 && bif.resp_ready[m_owner]) begin
      log_owner[n_log] = m_owner;
      log_rdata[n_log] = bif.resp_rdata;
      log_err[n_log]   = bif.resp_error;
      n_log++;
      m_busy = 1'b0;
    end else if (exp_rdy != 2'b00) begin
      model_accept(g);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    drive_phase();
    @(negedge clk);
    sample_phase();
  endtask

  task automatic run_until_idle(input int budget);
    int  n;
    logic idle;
    n = 0;
    while ((head[0] < tail[0] || head[1] < tail[1] || m_busy) && n < budget) begin
      step();
      n++;
    end
    idle = !(head[0] < tail[0] || head[1] < tail[1] || m_busy);
    check("drain_within_budget", 64'(idle), 64'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; upd_cnt = 0; n_log = 0; allow_drop = 1'b0;
    for (int r = 0; r < 2; r++) begin
      head[r] = 0; tail[r] = 0; pres[r] = 1'b0; wait_rsp[r] = 1'b0; hold_cnt[r] = 0;
    end
    bif.req_valid = '0; bif.req_write = '0; bif.req_addr = '0;
    bif.req_wdata = '0; bif.req_wstrb = '0; bif.resp_ready = '0;
    rst = 1'b1;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(bif.req_ready), 64'd0);
    check("reset_resp_valid", 64'(bif.resp_valid), 64'd0);
    check("reset_resp_rdata", 64'(bif.resp_rdata), 64'd0);
    check("reset_resp_error", 64'(bif.resp_error), 64'd0);
    check("reset_regs_out", regs_out, RESET_VALUE);
    check("reset_regs_update", 64'(regs_update), 64'd0);
    rst = 1'b0;

    // reads of both words from requester 0
    base = n_log;
    push(0, 1'b0, 4'd0, 32'd0, 4'h0, 0);
    push(0, 1'b0, 4'd1, 32'd0, 4'h0, 1);
    run_until_idle(50);
    check("rd_addr0", 64'(log_rdata[base]), 64'h0000_0000_ABCD_1234);
    check("rd_addr0_err", 64'(log_err[base]), 64'd0);
    check("rd_addr1", 64'(log_rdata[base + 1]), 64'h0000_0000_0040_1020);
    check("rd_addr1_err", 64'(log_err[base + 1]), 64'd0);

    // partial-strobe write from requester 1, then the identical write again
    upd_base = upd_cnt;
    push(1, 1'b1, 4'd1, 32'hDEAD_BEEF, 4'b0011, 0);
    run_until_idle(50);
    check("wr_upper", 64'(regs_out[63:32]), 64'h0000_0000_0040_BEEF);
    check("wr_update_once", 64'(upd_cnt - upd_base), 64'd1);
    upd_base = upd_cnt;
    push(1, 1'b1, 4'd1, 32'hDEAD_BEEF, 4'b0011, 0);
    run_until_idle(50);
    check("wr_repeat_no_update", 64'(upd_cnt - upd_base), 64'd0);

    // write to read-only version word is ignored without error
    base = n_log; upd_base = upd_cnt;
    push(1, 1'b1, 4'd0, 32'd0, 4'hF, 0);
    run_until_idle(50);
    check("ro_version", 64'(regs_out[31:0]), 64'h0000_0000_ABCD_1234);
    check("ro_err", 64'(log_err[base]), 64'd0);
    check("ro_no_update", 64'(upd_cnt - upd_base), 64'd0);

    // continuous contention with slow response acceptance
    base = n_log;
    push(0, 1'b0, 4'd0, 32'd0, 4'h0, 3);
    push(0, 1'b0, 4'd1, 32'd0, 4'h0, 3);
    push(1, 1'b0, 4'd1, 32'd0, 4'h0, 3);
    push(1, 1'b0, 4'd0, 32'd0, 4'h0, 3);
    run_until_idle(100);
    for (int i = 0; i < 4; i++) check("rr_order", 64'(log_owner[base + i]), 64'(i % 2));

    // invalid address
    base = n_log;
    push(0, 1'b0, 4'd5, 32'd0, 4'h0, 0);
    run_until_idle(50);
    check("bad_addr_err", 64'(log_err[base]), 64'd1);
    check("bad_addr_rdata", 64'(log_rdata[base]), 64'd0);
    check("bad_addr_regs", regs_out, 64'h0040_BEEF_ABCD_1234);

    // reset while a write response is pending, with requester 0 waiting
    push(1, 1'b1, 4'd1, 32'h1234_5678, 4'hF, 1000);
    push(1, 1'b0, 4'd1, 32'd0, 4'h0, 0);
    for (int i = 0; i < 20 && !(wait_rsp[1] && hold_cnt[1] >= 1); i++) step();
    check("pre_rst_upper", 64'(regs_out[63:32]), 64'h0000_0000_1234_5678);
    push(0, 1'b0, 4'd0, 32'd0, 4'h0, 0);
    step();
    step();
    rst = 1'b1;
    wait_rsp[1] = 1'b0;
    bif.resp_ready[1] = 1'b0;
    head[1]++;
    present(1);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_resp_valid", 64'(bif.resp_valid), 64'd0);
    check("rst_regs_out", regs_out, RESET_VALUE);
    check("rst_req_ready", 64'(bif.req_ready), 64'd1);
    base = n_log;
    sample_phase();
    run_until_idle(50);
    check("rst_first_owner", 64'(log_owner[base]), 64'd0);
    check("rst_second_owner", 64'(log_owner[base + 1]), 64'd1);
    check("rst_rd_upper", 64'(log_rdata[base + 1]), 64'h0000_0000_0040_1020);

    // random traffic, including withdrawn requests
    allow_drop = 1'b1;
    for (int i = 0; i < 120; i++) begin
      for (int r = 0; r < 2; r++) begin
        push(r, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1)),
             $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end
    end
    run_until_idle(5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
